// File: rtl/ao221_stim_sequencer_if.sv
// Handshake and result bus between the power-harness controller and the AO221 stimulus sequencer.
interface ao221_stim_sequencer_if #(
  parameter int unsigned CntW = 16
) ();
  logic            start;
  logic            abort;
  logic            q_in;
  logic [4:0]      stim;
  logic            exp;
  logic            busy;
  logic            done;
  logic            mismatch;
  logic [CntW-1:0] err_cnt;
  logic [CntW-1:0] tog_cnt;

  modport master (
    output start, abort, q_in,
    input  stim, exp, busy, done, mismatch, err_cnt, tog_cnt
  );

  modport slave (
    input  start, abort, q_in,
    output stim, exp, busy, done, mismatch, err_cnt, tog_cnt
  );
endinterface

// File: rtl/ao221_stim_sequencer.sv
// Sweeps all 32 input patterns of an AO221 cell, samples its output and counts toggles/errors.
// Define GRAY_ORDER_EN to sweep patterns in Gray-code order instead of binary order.
module ao221_stim_sequencer #(
  parameter int unsigned HoldCyc = 4,
  parameter int unsigned Passes  = 1,
  parameter int unsigned CntW    = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  ao221_stim_sequencer_if.slave bus
);

  localparam int unsigned HoldW = $clog2(HoldCyc);
  localparam int unsigned PassW = (Passes > 1) ? $clog2(Passes) : 1;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic [4:0]       k_q;
  logic [PassW-1:0] pass_q;
  logic [4:0]       stim_q;
  logic             busy_q, done_q, mismatch_q;
  logic             first_q, prev_q;
  logic [CntW-1:0]  err_q, tog_q;

  logic [4:0] k_next, pat_next;
  logic       exp_w, sample, last_pat, last_pass, err_hit, tog_hit;

  assign exp_w  = (stim_q[0] & stim_q[1]) | (stim_q[2] & stim_q[3]) | stim_q[4];
  assign k_next = k_q + 5'd1;
`ifdef GRAY_ORDER_EN
  assign pat_next = k_next ^ (k_next >> 1);
`else
  assign pat_next = k_next;
`endif

  assign sample    = (hold_q == HoldW'(HoldCyc - 1));
  assign last_pat  = (k_q == 5'd31);
  assign last_pass = (pass_q == PassW'(Passes - 1));
  assign err_hit   = (bus.q_in != exp_w);
  // The first sample of a run has no predecessor, so it never counts as a toggle.
  assign tog_hit   = !first_q && (bus.q_in != prev_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      k_q        <= '0;
      pass_q     <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      first_q    <= 1'b0;
      prev_q     <= 1'b0;
      err_q      <= '0;
      tog_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= StIdle;
        stim_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q    <= StRun;
              busy_q     <= 1'b1;
              stim_q     <= '0;
              k_q        <= '0;
              hold_q     <= '0;
              pass_q     <= '0;
              first_q    <= 1'b1;
              err_q      <= '0;
              tog_q      <= '0;
              mismatch_q <= 1'b0;
            end
          end
          StRun: begin
            if (sample) begin
              hold_q  <= '0;
              prev_q  <= bus.q_in;
              first_q <= 1'b0;
              if (err_hit) begin
                mismatch_q <= 1'b1;
                if (err_q != CntMax) err_q <= err_q + 1'b1;
              end
              if (tog_hit && (tog_q != CntMax)) tog_q <= tog_q + 1'b1;
              k_q    <= k_next;
              stim_q <= pat_next;
              if (last_pat) begin
                if (last_pass) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  stim_q  <= '0;
                end else begin
                  pass_q <= pass_q + 1'b1;
                end
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.stim     = stim_q;
  assign bus.exp      = exp_w;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_q;
  assign bus.tog_cnt  = tog_q;

endmodule
